// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller host port (A: read-only fetcher, B: read/write).
// Optional command watchdog enabled by defining ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 16,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    output logic                  a_rd_valid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  b_rd_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_enable,
    output logic                  mem_rd_enable,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_ready,
    input  logic                  mem_busy,
    output logic                  timeout_err
);

    // Handshake: a requester holds req and its fields until the 1-cycle ack;
    // rd_valid is a 1-cycle pulse and rd_data holds until the next capture.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_WR = 3'd2,
        WAIT_RD = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t                state, state_nxt;
    logic                  owner_b, owner_b_nxt;
    logic                  op_we, op_we_nxt;
    logic [7:0]            starve_cnt, starve_cnt_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wr_data_nxt;
    logic                  mem_wr_enable_nxt, mem_rd_enable_nxt;
    logic                  a_ack_nxt, b_ack_nxt;
    logic                  a_rd_valid_nxt, b_rd_valid_nxt;
    logic [DATA_WIDTH-1:0] a_rd_data_nxt, b_rd_data_nxt;
    logic                  grant_b;
    logic                  timeout_hit;

    // B wins when A is idle or A has used up its consecutive-grant allowance.
    assign grant_b = b_req && (!a_req || (starve_cnt == STARVE_MAX));

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th cycle spent outside IDLE.
    assign timeout_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE || state_nxt == IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt         = state;
        owner_b_nxt       = owner_b;
        op_we_nxt         = op_we;
        starve_cnt_nxt    = starve_cnt;
        mem_addr_nxt      = mem_addr;
        mem_wr_data_nxt   = mem_wr_data;
        mem_wr_enable_nxt = mem_wr_enable;
        mem_rd_enable_nxt = mem_rd_enable;
        a_ack_nxt         = 1'b0;
        b_ack_nxt         = 1'b0;
        a_rd_valid_nxt    = 1'b0;
        b_rd_valid_nxt    = 1'b0;
        a_rd_data_nxt     = a_rd_data;
        b_rd_data_nxt     = b_rd_data;

        if (!b_req) begin
            starve_cnt_nxt = '0;
        end

        case (state)
            IDLE: begin
                if (!mem_busy && (a_req || b_req)) begin
                    owner_b_nxt = grant_b;
                    if (grant_b) begin
                        op_we_nxt       = b_we;
                        mem_addr_nxt    = b_addr;
                        mem_wr_data_nxt = b_wr_data;
                        starve_cnt_nxt  = '0;
                    end else begin
                        op_we_nxt       = 1'b0;
                        mem_addr_nxt    = a_addr;
                        mem_wr_data_nxt = '0;
                        if (b_req && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt_nxt = starve_cnt + 8'd1;
                        end
                    end
                    mem_wr_enable_nxt = grant_b && b_we;
                    mem_rd_enable_nxt = !(grant_b && b_we);
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_busy) begin
                    mem_wr_enable_nxt = 1'b0;
                    mem_rd_enable_nxt = 1'b0;
                    a_ack_nxt         = !owner_b;
                    b_ack_nxt         = owner_b;
                    state_nxt         = op_we ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_WR: begin
                if (!mem_busy) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_RD: begin
                if (mem_rd_ready) begin
                    if (owner_b) begin
                        b_rd_data_nxt  = mem_rd_data;
                        b_rd_valid_nxt = 1'b1;
                    end else begin
                        a_rd_data_nxt  = mem_rd_data;
                        a_rd_valid_nxt = 1'b1;
                    end
                    state_nxt = mem_busy ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Watchdog abandons the command outright: no ack, no read data.
        if (timeout_hit) begin
            state_nxt         = IDLE;
            mem_wr_enable_nxt = 1'b0;
            mem_rd_enable_nxt = 1'b0;
            a_ack_nxt         = 1'b0;
            b_ack_nxt         = 1'b0;
            a_rd_valid_nxt    = 1'b0;
            b_rd_valid_nxt    = 1'b0;
            a_rd_data_nxt     = a_rd_data;
            b_rd_data_nxt     = b_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner_b       <= 1'b0;
            op_we         <= 1'b0;
            starve_cnt    <= '0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            mem_wr_enable <= 1'b0;
            mem_rd_enable <= 1'b0;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            a_rd_valid    <= 1'b0;
            b_rd_valid    <= 1'b0;
            a_rd_data     <= '0;
            b_rd_data     <= '0;
        end else begin
            state         <= state_nxt;
            owner_b       <= owner_b_nxt;
            op_we         <= op_we_nxt;
            starve_cnt    <= starve_cnt_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_wr_data   <= mem_wr_data_nxt;
            mem_wr_enable <= mem_wr_enable_nxt;
            mem_rd_enable <= mem_rd_enable_nxt;
            a_ack         <= a_ack_nxt;
            b_ack         <= b_ack_nxt;
            a_rd_valid    <= a_rd_valid_nxt;
            b_rd_valid    <= b_rd_valid_nxt;
            a_rd_data     <= a_rd_data_nxt;
            b_rd_data     <= b_rd_data_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural SDRAM controller model.
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_sdram_port_arbiter;

    localparam int AW = 23;
    localparam int DW = 16;

    typedef struct {
        logic          port_b;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          rdy_late;
    } vec_t;

    logic          clk, rst_n;
    logic          a_req, a_ack, a_rd_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rd_data;
    logic          b_req, b_we, b_ack, b_rd_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wr_data, b_rd_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          mem_wr_enable, mem_rd_enable, mem_rd_ready, mem_busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int a_ack_cnt = 0, b_ack_cnt = 0, a_rv_cnt = 0, b_rv_cnt = 0;
    logic [DW-1:0] a_exp_q[$];
    logic [DW-1:0] b_exp_q[$];
    logic          grant_log[$];

    // controller model state
    logic [DW-1:0] mem_model [0:1023];
    bit            m_active, m_rd, m_both, never_busy, spur_req;
    int            m_cnt, rdy_at;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          busy_at_pos;
    logic          pa_ack, pb_ack, p_en;

    sdram_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req        (a_req),
        .a_addr       (a_addr),
        .a_ack        (a_ack),
        .a_rd_data    (a_rd_data),
        .a_rd_valid   (a_rd_valid),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wr_data    (b_wr_data),
        .b_ack        (b_ack),
        .b_rd_data    (b_rd_data),
        .b_rd_valid   (b_rd_valid),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_enable(mem_wr_enable),
        .mem_rd_enable(mem_rd_enable),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_ready (mem_rd_ready),
        .mem_busy     (mem_busy),
        .timeout_err  (timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pre_data(input int a);
        return DW'(a * 3 + 'h1000);
    endfunction

    // ---------------- controller model ----------------
    // Busy rises 2 cycles after enable is seen and stays up 6 cycles; read data at cycle rdy_at.
    initial begin
        mem_busy = 1'b0; mem_rd_ready = 1'b0; mem_rd_data = '0;
        m_active = 1'b0; m_cnt = 0; rdy_at = 6; never_busy = 1'b0; spur_req = 1'b0;
        m_rd = 1'b0; m_both = 1'b0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 1024; i++) mem_model[i] = pre_data(i);
        forever begin
            @(negedge clk);
            mem_rd_ready = 1'b0;
            if (!rst_n) begin
                m_active = 1'b0;
                mem_busy = 1'b0;
            end else if (m_active) begin
                m_cnt++;
                mem_busy = (m_cnt >= 2) && (m_cnt <= 7);
                if (m_rd && m_cnt == rdy_at) begin
                    mem_rd_ready = 1'b1;
                    mem_rd_data  = mem_model[m_addr[9:0]];
                end
                if (m_cnt >= 8 && m_cnt >= rdy_at) begin
                    m_active = 1'b0;
                    if (!m_rd) mem_model[m_addr[9:0]] = m_wdata;
                end
            end else if (spur_req) begin
                mem_rd_ready = 1'b1;
                mem_rd_data  = 16'hDEAD;
                spur_req     = 1'b0;
            end else if ((mem_wr_enable || mem_rd_enable) && !never_busy) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_rd     = mem_rd_enable;
                m_both   = mem_wr_enable && mem_rd_enable;
                m_addr   = mem_addr;
                m_wdata  = mem_wr_data;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            busy_at_pos = mem_busy;
        end
    end

    initial begin
        pa_ack = 1'b0; pb_ack = 1'b0; p_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pa_ack = 1'b0; pb_ack = 1'b0; p_en = 1'b0;
                continue;
            end
            if (a_ack) begin
                a_ack_cnt++;
                grant_log.push_back(1'b0);
                check("a_ack_width", pa_ack, 0);
            end
            if (b_ack) begin
                b_ack_cnt++;
                grant_log.push_back(1'b1);
                check("b_ack_width", pb_ack, 0);
            end
            if ((mem_wr_enable || mem_rd_enable) && !p_en)
                check("grant_while_busy", busy_at_pos, 0);
            if (a_rd_valid) begin
                a_rv_cnt++;
                if (a_exp_q.size() == 0) check("a_rd_valid_unexpected", 1, 0);
                else check("a_rd_data", a_rd_data, a_exp_q.pop_front());
            end
            if (b_rd_valid) begin
                b_rv_cnt++;
                if (b_exp_q.size() == 0) check("b_rd_valid_unexpected", 1, 0);
                else check("b_rd_data", b_rd_data, b_exp_q.pop_front());
            end
            pa_ack = a_ack;
            pb_ack = b_ack;
            p_en   = mem_wr_enable || mem_rd_enable;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_model_idle();
        for (int i = 0; i < 60 && m_active; i++) tick();
        repeat (2) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {a_ack, b_ack, a_rd_valid, b_rd_valid,
                               mem_wr_enable, mem_rd_enable, timeout_err}, 0);
        check({tag, "_a_rd_data"}, a_rd_data, 0);
        check({tag, "_b_rd_data"}, b_rd_data, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int  ack0, rv0, orv0;
        bit  got;
        rdy_at = v.rdy_late ? 8 : 6;
        ack0 = v.port_b ? b_ack_cnt : a_ack_cnt;
        rv0  = v.port_b ? b_rv_cnt : a_rv_cnt;
        orv0 = v.port_b ? a_rv_cnt : b_rv_cnt;
        if (!v.we) begin
            if (v.port_b) b_exp_q.push_back(v.exp_rdata);
            else          a_exp_q.push_back(v.exp_rdata);
        end
        if (v.port_b) begin
            b_we = v.we; b_addr = v.addr; b_wr_data = v.wdata; b_req = 1'b1;
        end else begin
            a_addr = v.addr; a_req = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            got = ((v.port_b ? b_ack_cnt : a_ack_cnt) != ack0);
        end
        check({tag, "_ack"}, got, 1);
        a_req = 1'b0;
        b_req = 1'b0;
        check({tag, "_en_after_ack"}, {mem_wr_enable, mem_rd_enable}, 0);
        check({tag, "_op_we"}, !m_rd, v.we);
        check({tag, "_both_en"}, m_both, 0);
        check({tag, "_mem_addr"}, m_addr, v.addr);
        if (v.we) check({tag, "_mem_wr_data"}, m_wdata, v.wdata);
        if (!v.we) begin
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                tick();
                got = ((v.port_b ? b_rv_cnt : a_rv_cnt) != rv0);
            end
            check({tag, "_rd_valid"}, got, 1);
            repeat (3) tick();
            check({tag, "_rd_data_hold"}, v.port_b ? b_rd_data : a_rd_data, v.exp_rdata);
            check({tag, "_rd_valid_count"}, (v.port_b ? b_rv_cnt : a_rv_cnt) - rv0, 1);
            check({tag, "_other_rd_valid"}, (v.port_b ? a_rv_cnt : b_rv_cnt) - orv0, 0);
        end
        wait_model_idle();
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[9];
    logic exp_order[10];

    initial begin
        int a0, b0, ar0, br0;
        logic [DW-1:0] ard0, brd0;

        vecs[0] = '{1'b1, 1'b1, 23'h000010, 16'hFF00, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 23'h000010, 16'h0000, 16'hFF00, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 23'h000010, 16'h0000, 16'hFF00, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 23'h000005, 16'h0000, 16'h100F, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 23'h000020, 16'h1234, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 23'h000020, 16'h0000, 16'h1234, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 23'h00027F, 16'h0000, 16'h177D, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 23'h0003FF, 16'hA5A5, 16'h0000, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 23'h0003FF, 16'h0000, 16'hA5A5, 1'b0};
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wr_data = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // A burst with B idle: 640 reads in address order
        a0 = a_ack_cnt; ar0 = a_rv_cnt; br0 = b_rv_cnt;
        for (int i = 0; i < 640; i++) a_exp_q.push_back(pre_data(i));
        a_req = 1'b1;
        for (int i = 0; i < 640; i++) begin
            a_addr = AW'(i);
            for (int k = 0; k < 100 && a_ack_cnt == a0 + i; k++) tick();
            if (a_ack_cnt != a0 + i + 1) break;
        end
        a_req = 1'b0;
        for (int i = 0; i < 200 && a_exp_q.size() != 0; i++) tick();
        check("burst_acks", a_ack_cnt - a0, 640);
        check("burst_rd_valids", a_rv_cnt - ar0, 640);
        check("burst_b_rd_valids", b_rv_cnt - br0, 0);
        check("burst_queue_empty", a_exp_q.size(), 0);
        a_exp_q.delete();
        wait_model_idle();

        // table of single transactions
        for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // A and B both requesting continuously: starvation limit forces B every fifth grant
        grant_log.delete();
        rdy_at = 6;
        for (int i = 0; i < 8; i++) a_exp_q.push_back(16'h100F);
        a_addr = 23'h000005; a_req = 1'b1;
        b_we = 1'b1; b_addr = 23'h000300; b_wr_data = 16'hBEEF; b_req = 1'b1;
        for (int i = 0; i < 400 && grant_log.size() < 10; i++) tick();
        a_req = 1'b0;
        b_req = 1'b0;
        check("grant_count", grant_log.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("grant_order_%0d", i),
                  (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_order[i]);
        for (int i = 0; i < 100 && a_exp_q.size() != 0; i++) tick();
        check("grant_a_reads_done", a_exp_q.size(), 0);
        a_exp_q.delete();
        wait_model_idle();
        check("grant_b_write_landed", mem_model[10'h300], 16'hBEEF);

        // rd_ready while idle must be ignored
        ar0 = a_rv_cnt; br0 = b_rv_cnt; ard0 = a_rd_data; brd0 = b_rd_data;
        spur_req = 1'b1;
        repeat (4) tick();
        check("spur_rd_valid", (a_rv_cnt - ar0) + (b_rv_cnt - br0), 0);
        check("spur_a_rd_data", a_rd_data, ard0);
        check("spur_b_rd_data", b_rd_data, brd0);

        // reset while in WAIT_RD: everything clears and the read is abandoned
        rdy_at = 6;
        b0 = b_ack_cnt; br0 = b_rv_cnt;
        b_we = 1'b0; b_addr = 23'h000010; b_req = 1'b1;
        for (int i = 0; i < 100 && b_ack_cnt == b0; i++) tick();
        check("rst_mid_ack", b_ack_cnt - b0, 1);
        b_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("rst_mid_no_rd_valid", b_rv_cnt - br0, 0);
        do_txn(vecs[8], "post_rst");

`ifdef ARB_TIMEOUT_EN
        // controller never goes busy: watchdog abandons the command after 15 ISSUE cycles
        begin
            int en_cycles;
            en_cycles = 0;
            b0 = b_ack_cnt;
            never_busy = 1'b1;
            b_we = 1'b1; b_addr = 23'h000040; b_wr_data = 16'h7777; b_req = 1'b1;
            for (int i = 0; i < 60 && !timeout_err; i++) begin
                tick();
                if (mem_wr_enable) en_cycles++;
            end
            check("tmo_err_set", timeout_err, 1);
            check("tmo_enable_cycles", en_cycles, 15);
            check("tmo_enable_dropped", mem_wr_enable, 0);
            check("tmo_no_ack", b_ack_cnt - b0, 0);
            never_busy = 1'b0;
            for (int i = 0; i < 100 && b_ack_cnt == b0; i++) tick();
            b_req = 1'b0;
            check("tmo_retry_ack", b_ack_cnt - b0, 1);
            wait_model_idle();
            check("tmo_retry_write", mem_model[10'h040], 16'h7777);
            check("tmo_err_sticky", timeout_err, 1);
        end
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single host port of sdram_controller between two requesters. Port A is the LCD frame-buffer line fetcher (read-only, latency-critical). Port B is the system/test FSM (read and write).
- Sequences the controller's enable/busy/rd_ready handshake so that exactly one command is outstanding at any time.
- Sits in the sys_clk domain, between the requesters and i_sdram_controller.

Parameters:
- ADDR_WIDTH, 23, host word address width.
- DATA_WIDTH, 16, host data width.
- STARVE_LIMIT, 4, consecutive A grants allowed while B is pending before B is forced; range 1..255.
- TIMEOUT_CYCLES, 1023, watchdog limit in clk cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (sys_clk, 96 MHz)
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A read request; held with a_addr until a_ack
- a_addr  in  ADDR_WIDTH  port A address
- a_ack  out  1  1-cycle pulse: A command accepted by controller
- a_rd_data  out  DATA_WIDTH  port A read data
- a_rd_valid  out  1  1-cycle pulse: a_rd_data valid
- b_req  in  1  port B request; held with b_we/b_addr/b_wr_data until b_ack
- b_we  in  1  1 = write, 0 = read
- b_addr  in  ADDR_WIDTH  port B address
- b_wr_data  in  DATA_WIDTH  port B write data
- b_ack  out  1  1-cycle pulse: B command accepted
- b_rd_data  out  DATA_WIDTH  port B read data
- b_rd_valid  out  1  1-cycle pulse: b_rd_data valid
- mem_addr  out  ADDR_WIDTH  drives both controller wr_addr and rd_addr
- mem_wr_data  out  DATA_WIDTH  controller wr_data
- mem_wr_enable  out  1  controller wr_enable
- mem_rd_enable  out  1  controller rd_enable
- mem_rd_data  in  DATA_WIDTH  controller rd_data
- mem_rd_ready  in  1  controller rd_ready
- mem_busy  in  1  controller busy
- timeout_err  out  1  sticky watchdog error (constant 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset: all outputs 0, FSM = IDLE, owner = A, starvation counter = 0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_WR, WAIT_RD, DRAIN.
- IDLE:
  - Grants only when mem_busy = 0 and at least one req is high.
  - Winner: B if b_req and (!a_req or starve_cnt == STARVE_LIMIT); otherwise A.
  - Registers owner, address, data and op; drives mem_*_enable = 1 the next cycle; goes to ISSUE.
- ISSUE:
  - Holds enable and fields until mem_busy = 1 is sampled.
  - On that cycle: enable drops to 0, owner's ack pulses, next state is WAIT_WR for a write or WAIT_RD for a read.
- WAIT_WR: when mem_busy = 0, go to IDLE.
- WAIT_RD:
  - When mem_rd_ready = 1: capture mem_rd_data into owner's rd_data and pulse owner's rd_valid on the next cycle.
  - Then go to DRAIN if mem_busy = 1, else IDLE.
- DRAIN: when mem_busy = 0, go to IDLE.
- Command throughput: minimum IDLE->IDLE is 3 cycles plus controller time; no grant is issued in the cycle a command completes.
- Starvation counter:
  - Increments on each A grant while b_req = 1, saturating at STARVE_LIMIT.
  - Clears on a B grant or on any cycle with b_req = 0.
- Simultaneous a_req and b_req with starve_cnt < STARVE_LIMIT: A wins.
- a_rd_data / b_rd_data hold their value until the next capture for that port.
- A requester dropping req before its ack is a protocol violation. It is not supported; the arbiter keeps the latched command.
- mem_rd_ready outside WAIT_RD is ignored.
- Reset mid-operation: everything returns to reset values immediately. An in-flight controller op is abandoned, and no ack or rd_valid is emitted.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in ISSUE, WAIT_WR, WAIT_RD and DRAIN and clears on entry to IDLE.
  - If it reaches TIMEOUT_CYCLES: enables drop, FSM goes to IDLE, timeout_err is set sticky until reset.
  - No ack is issued if the timeout occurs in ISSUE. No rd_valid is issued if it occurs in WAIT_RD.
- Without the macro: no counter; timeout_err tied 0; the FSM waits indefinitely.

Test Plan:
- Single B write: b_req = 1, b_we = 1, b_addr = 0x000010, b_wr_data = 0xFF00; model busy 2 cycles after enable for 6 cycles -> mem_wr_enable high until busy, one b_ack pulse, then IDLE.
- B read-back of 0x000010 with model rd_data = 0xFF00 -> b_rd_valid single pulse, b_rd_data = 0xFF00, a_rd_valid stays 0.
- A and B requesting continuously, STARVE_LIMIT = 4 -> grant order A,A,A,A,B,A,A,A,A,B; no command issued while mem_busy = 1.
- A burst: A reads addresses 0..639 with B idle -> 640 a_ack and 640 a_rd_valid pulses in order; data matches the model.
- Reset asserted in WAIT_RD -> all outputs 0 within the same cycle; after release, a fresh request completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 15, model never asserts busy -> after 15 cycles in ISSUE: enable drops, timeout_err = 1, no ack; timeout_err stays 1 through later successful ops.
